// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external combinational ALU between two requesters.
//
// Operation sequence (one operation in flight at a time):
//   IDLE : round-robin grant between req0/req1. The winner's operands and select
//          are latched onto alu_a/alu_b/alu_sel on the accept edge.
//   EXEC : one cycle for the ALU to settle. alu_res/alu_z are captured at its end.
//   RESP : the captured result is presented on the winner's response channel
//          and held there until the winner takes it.
//
// Ports:
//   clk, rst_n              rising-edge clock, asynchronous active-low reset
//   reqN_valid/ready        request handshake for requester N (N = 0, 1)
//   reqN_a/b/sel            operands and ALU select for requester N
//   rspN_valid/ready        response handshake for requester N
//   rspN_res/z              result and zero flag; driven 0 unless rspN_valid is high
//   alu_a/b/sel             registered ALU inputs, held between operations
//   alu_res, alu_z          combinational ALU outputs
//   busy                    high whenever an operation is in flight
module alu_arbiter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SELW  = 4
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [SELW-1:0]  req0_sel,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_res,
  output logic             rsp0_z,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [SELW-1:0]  req1_sel,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_res,
  output logic             rsp1_z,

  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [SELW-1:0]  alu_sel,
  input  logic [WIDTH-1:0] alu_res,
  input  logic             alu_z,

  output logic             busy
);

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StResp
  } state_e;

  state_e           state_q, state_d;
  logic             ptr_q, ptr_d;       // requester favoured when both are valid
  logic             gnt_id_q, gnt_id_d; // requester that owns the operation in flight
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [SELW-1:0]  alu_sel_q, alu_sel_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             z_q, z_d;

  // Arbitration signals
  logic             any_valid;
  logic             win_id;
  logic             grant_en;
  logic             accept;
  logic             rsp_done;
  logic [WIDTH-1:0] win_a;
  logic [WIDTH-1:0] win_b;
  logic [SELW-1:0]  win_sel;

  // ---------------------------------------------------------------------------
  // Grant: a lone requester wins outright; on contention the pointer decides.
  // Re-evaluated every IDLE cycle, so a requester dropping valid loses nothing.
  // ---------------------------------------------------------------------------
  always_comb begin
    any_valid = req0_valid | req1_valid;
    win_id    = (req0_valid & req1_valid) ? ptr_q : req1_valid;
    // Gated by rst_n so no ready escapes while reset is held.
    grant_en  = rst_n & (state_q == StIdle) & any_valid;
    accept    = grant_en;  // ready is only raised towards a valid requester
    win_a     = win_id ? req1_a   : req0_a;
    win_b     = win_id ? req1_b   : req0_b;
    win_sel   = win_id ? req1_sel : req0_sel;
    // Only the granted requester's rsp_ready completes the response.
    rsp_done  = (state_q == StResp) & (gnt_id_q ? rsp1_ready : rsp0_ready);
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_id_d  = gnt_id_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_sel_d = alu_sel_q;
    res_d     = res_q;
    z_d       = z_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          alu_a_d   = win_a;
          alu_b_d   = win_b;
          alu_sel_d = win_sel;
          gnt_id_d  = win_id;
          state_d   = StExec;
        end
      end

      StExec: begin
        res_d   = alu_res;
        z_d     = alu_z;
        state_d = StResp;
      end

      StResp: begin
        if (rsp_done) begin
          // Pointer moves only on completion, towards the requester that lost.
          ptr_d   = ~gnt_id_q;
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      ptr_q     <= 1'b0;
      gnt_id_q  <= 1'b0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_sel_q <= '0;
      res_q     <= '0;
      z_q       <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_id_q  <= gnt_id_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_sel_q <= alu_sel_d;
      res_q     <= res_d;
      z_q       <= z_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    req0_ready = grant_en & ~win_id;
    req1_ready = grant_en &  win_id;

    rsp0_valid = (state_q == StResp) & ~gnt_id_q;
    rsp1_valid = (state_q == StResp) &  gnt_id_q;

    // Non-granted (or idle) response channels are held at zero.
    rsp0_res   = rsp0_valid ? res_q : '0;
    rsp0_z     = rsp0_valid & z_q;
    rsp1_res   = rsp1_valid ? res_q : '0;
    rsp1_z     = rsp1_valid & z_q;

    alu_a      = alu_a_q;
    alu_b      = alu_b_q;
    alu_sel    = alu_sel_q;

    busy       = (state_q != StIdle);
  end

endmodule
